// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues instruction-memory reads at the
//               current PC, tells the PC register when to advance, and feeds
//               the IF/ID pipeline register. A one-entry hold buffer absorbs
//               one fetch that completes while decode is stalled. A flush that
//               arrives while a read is outstanding and unanswered leaves the
//               block in a drop state, which waits for and discards that late
//               response.
//
// Ports       : clock        - sole clock, rising edge
//               reset        - asynchronous, active-low reset
//               pc           - current PC from the PC register
//               pc_advance   - combinational; PC register advances by 4
//               imem_req     - instruction read request
//               imem_addr    - instruction read address
//               imem_rdata   - read data, valid with imem_ack
//               imem_ack     - read complete (may coincide with imem_req)
//               flush        - discard in-flight/buffered fetches
//               id_ready     - decode accepts if_id_* this cycle
//               if_id_valid  - IF/ID register holds a valid instruction
//               if_id_pc     - PC of the held instruction
//               if_id_inst   - held instruction word
//               if_id_fault  - held entry is a misaligned-fetch fault
//
// Config      : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned PC in the
//               request state produces a fault entry (NOP) instead of a read.
//               When undefined, the address is word-aligned and faults are 0.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        flush,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_fault
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_drop_addr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic        r_hold_fault;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_fault;

  logic        w_misalign;
  logic        w_accept;
  logic        w_slot_free;
  logic [31:0] w_req_addr;
  logic [31:0] w_new_inst;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned PC never reaches memory; it completes at once as a fault.
  assign w_misalign = (r_state == S_REQ) && (pc[1:0] != 2'b00);
  assign w_req_addr = pc;
`else
  assign w_misalign = 1'b0;
  assign w_req_addr = {pc[31:2], 2'b00};
`endif

  // Acceptance: a completed (or trapped) fetch that is not being flushed.
  assign w_accept    = (r_state == S_REQ) && !flush && (imem_ack || w_misalign);
  assign w_slot_free = !r_valid || id_ready;
  assign w_new_inst  = w_misalign ? C_NOP : imem_rdata;

  assign pc_advance  = w_accept;

  // Request/address decode from the registered state; forced low by reset
  // because reset holds the state in IDLE.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0000_0000;
    case (r_state)
      S_REQ: begin
        imem_req  = !w_misalign;
        imem_addr = w_req_addr;
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = r_drop_addr;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = 32'h0000_0000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_drop_addr  <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
      r_hold_inst  <= 32'h0000_0000;
      r_hold_fault <= 1'b0;
      r_valid      <= 1'b0;
      r_pc         <= 32'h0000_0000;
      r_inst       <= C_NOP;
      r_fault      <= 1'b0;
    end else begin
      // ---------------- state and side buffers ----------------
      case (r_state)
        S_IDLE: r_state <= S_REQ;

        S_REQ: begin
          if (flush) begin
            // With no answer yet the read is still in flight: remember where
            // it went so the late response can be recognised and dropped.
            if (!(imem_ack || w_misalign)) begin
              r_drop_addr <= w_req_addr;
              r_state     <= S_DROP;
            end
          end else if (w_accept && !w_slot_free) begin
            r_hold_pc    <= pc;
            r_hold_inst  <= w_new_inst;
            r_hold_fault <= w_misalign;
            r_state      <= S_HOLD;
          end
        end

        // Leaving HOLD invalidates the buffer, so a flush needs no data wipe;
        // the buffer contents only change when a new entry is captured.
        S_HOLD: if (flush || id_ready) r_state <= S_REQ;

        // A redirect while dropping keeps draining the old request.
        S_DROP: if (!flush && imem_ack) r_state <= S_REQ;

        default: r_state <= S_IDLE;
      endcase

      // ---------------- IF/ID register ----------------
      if (flush) begin
        r_valid <= 1'b0;
      end else if ((r_state == S_HOLD) && id_ready) begin
        r_valid <= 1'b1;
        r_pc    <= r_hold_pc;
        r_inst  <= r_hold_inst;
        r_fault <= r_hold_fault;
      end else if (w_accept && w_slot_free) begin
        r_valid <= 1'b1;
        r_pc    <= pc;
        r_inst  <= w_new_inst;
        r_fault <= w_misalign;
      end else if (id_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign if_id_valid = r_valid;
  assign if_id_pc    = r_pc;
  assign if_id_inst  = r_inst;
  // Constant 0 unless the misalignment trap is compiled in.
  assign if_id_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A transaction-level model
//               (output entry, queue of buffered entries, drop flag) predicts
//               every output each cycle; the bench also models the PC register
//               and a memory with random response timing. Directed sequences
//               pin the model with literal expectations; a random phase follows.
//               Define FETCH_MISALIGN_TRAP_EN to also exercise the trap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_fault;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .flush       (flush),
    .id_ready    (id_ready),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_fault (if_id_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit          m_idle;
  bit          m_drop;
  logic [31:0] m_drop_addr;
  ent_t        m_buf[$];
  ent_t        m_out;
  bit          m_valid;
  logic [31:0] tb_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] fetch_addr(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a[1:0] != 2'b00;
`else
    return (a[1:0] & 2'b00) != 2'b00;
`endif
  endfunction

  task automatic model_reset();
    m_idle      = 1'b1;
    m_drop      = 1'b0;
    m_drop_addr = 32'h0;
    m_buf.delete();
    m_out       = '{pc: 32'h0, inst: NOP, fault: 1'b0};
    m_valid     = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, predict and compare
  // all outputs, then advance the model and the PC register.
  task automatic step(input bit f, input bit r, input bit a, input logic [31:0] tgt);
    bit          fetching, mis, e_req, e_adv;
    logic [31:0] e_addr;
    ent_t        nw;
    @(negedge clock);
    pc         = tb_pc;
    flush      = f;
    id_ready   = r;
    imem_rdata = $urandom;
    fetching   = !m_idle && (m_buf.size() == 0) && !m_drop;
    mis        = fetching && misaligned(pc);
    e_req      = (fetching && !mis) || m_drop;
    e_addr     = m_drop ? m_drop_addr : (fetching ? fetch_addr(pc) : 32'h0);
    imem_ack   = a && e_req;
    e_adv      = fetching && !f && (imem_ack || mis);
    #1;
    chk("imem_req",    32'(imem_req),    32'(e_req));
    chk("imem_addr",   imem_addr,        e_addr);
    chk("pc_advance",  32'(pc_advance),  32'(e_adv));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("if_id_pc",    if_id_pc,         m_out.pc);
    chk("if_id_inst",  if_id_inst,       m_out.inst);
    chk("if_id_fault", 32'(if_id_fault), 32'(m_out.fault));

    nw.pc    = pc;
    nw.inst  = mis ? NOP : imem_rdata;
    nw.fault = mis;
    if (f) begin
      if (!m_drop && fetching && !imem_ack && !mis) begin
        m_drop      = 1'b1;
        m_drop_addr = fetch_addr(pc);
      end
      m_valid = 1'b0;
      m_buf.delete();
      m_idle  = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (r) begin
        m_out   = m_buf.pop_front();
        m_valid = 1'b1;
      end
    end else if (m_drop) begin
      if (r) m_valid = 1'b0;
      if (imem_ack) m_drop = 1'b0;
    end else if (e_adv) begin
      if (!m_valid || r) begin
        m_out   = nw;
        m_valid = 1'b1;
      end else begin
        m_buf.push_back(nw);
      end
    end else if (r) begin
      m_valid = 1'b0;
    end

    if (f) tb_pc = tgt;
    else if (e_adv) tb_pc = tb_pc + 32'd4;
  endtask

  initial begin
    int adv_cnt;
    logic [31:0] tgt;
    model_reset();
    tb_pc = 32'h0100_0000;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_adv",   32'(pc_advance),  32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_pc",    if_id_pc,         32'h0);
    chk("rst_inst",  if_id_inst,       NOP);
    chk("rst_fault", 32'(if_id_fault), 32'd0);
    @(posedge clock);
    #2 reset = 1'b1;

    // ---------------- zero-wait streaming ----------------
    step(0, 1, 1, 32'h0);
    chk("zw_idle_req", 32'(imem_req), 32'd0);
    step(0, 1, 1, 32'h0);
    chk("zw_first_req", 32'(imem_req), 32'd1);
    chk("zw_addr0", imem_addr, 32'h0100_0000);
    chk("zw_adv0", 32'(pc_advance), 32'd1);
    step(0, 1, 1, 32'h0);
    chk("zw_valid0", 32'(if_id_valid), 32'd1);
    chk("zw_out0", if_id_pc, 32'h0100_0000);
    chk("zw_adv1", 32'(pc_advance), 32'd1);
    step(0, 1, 1, 32'h0);
    chk("zw_out1", if_id_pc, 32'h0100_0004);
    step(0, 1, 1, 32'h0);
    chk("zw_out2", if_id_pc, 32'h0100_0008);

    // ---------------- ack delayed 3 cycles ----------------
    adv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i == 3, 32'h0);
      chk("dl_req", 32'(imem_req), 32'd1);
      chk("dl_addr", imem_addr, 32'h0100_0010);
      adv_cnt += int'(pc_advance);
    end
    chk("dl_adv_pulses", adv_cnt, 32'd1);
    step(0, 1, 0, 32'h0);
    chk("dl_valid", 32'(if_id_valid), 32'd1);
    chk("dl_out", if_id_pc, 32'h0100_0010);

    // ---------------- stall into hold buffer ----------------
    step(0, 1, 1, 32'h0);              // load 0x01000014
    step(0, 0, 1, 32'h0);              // 0x01000018 accepted with slot blocked
    chk("hd_adv", 32'(pc_advance), 32'd1);
    step(0, 0, 1, 32'h0);
    chk("hd_req", 32'(imem_req), 32'd0);
    chk("hd_held", if_id_pc, 32'h0100_0014);
    step(0, 1, 1, 32'h0);
    chk("hd_req2", 32'(imem_req), 32'd0);
    chk("hd_held2", if_id_pc, 32'h0100_0014);
    step(0, 1, 0, 32'h0);
    chk("hd_buffered_out", if_id_pc, 32'h0100_0018);
    chk("hd_buffered_valid", 32'(if_id_valid), 32'd1);

    // ---------------- flush with outstanding request ----------------
    step(1, 1, 1, 32'h0100_0008);      // flush with ack: data discarded
    chk("fl_ack_adv", 32'(pc_advance), 32'd0);
    step(1, 1, 0, 32'h0100_0100);      // request at 0x01000008 left unanswered
    chk("fl_out_addr", imem_addr, 32'h0100_0008);
    step(0, 1, 0, 32'h0);
    chk("fl_drop_req", 32'(imem_req), 32'd1);
    chk("fl_drop_addr", imem_addr, 32'h0100_0008);
    step(0, 1, 1, 32'h0);              // late ack
    chk("fl_late_adv", 32'(pc_advance), 32'd0);
    step(0, 1, 1, 32'h0);
    chk("fl_new_addr", imem_addr, 32'h0100_0100);
    chk("fl_new_adv", 32'(pc_advance), 32'd1);
    step(0, 1, 0, 32'h0);
    chk("fl_new_out", if_id_pc, 32'h0100_0100);

`ifdef FETCH_MISALIGN_TRAP_EN
    // ---------------- misaligned fetch trap ----------------
    step(1, 1, 1, 32'h0100_0002);
    step(0, 1, 1, 32'h0);
    chk("ma_req", 32'(imem_req), 32'd0);
    chk("ma_adv", 32'(pc_advance), 32'd1);
    step(1, 1, 1, 32'h0100_0200);
    chk("ma_fault", 32'(if_id_fault), 32'd1);
    chk("ma_pc", if_id_pc, 32'h0100_0002);
    chk("ma_inst", if_id_inst, NOP);
`endif

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 3000; i++) begin
      tgt = 32'h0100_0000 + ($urandom_range(0, 255) << 2);
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
      step($urandom_range(0, 19) == 0, ($urandom % 4) != 0, ($urandom % 2) != 0, tgt);
    end

    // ---------------- reset during a request ----------------
    step(1, 1, 1, 32'h0100_0000);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h0);
    step(0, 1, 0, 32'h0);
    chk("ar_pre_valid", 32'(if_id_valid), 32'd1);
    chk("ar_pre_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_adv", 32'(pc_advance), 32'd0);
    chk("ar_valid", 32'(if_id_valid), 32'd0);
    chk("ar_inst", if_id_inst, NOP);
    chk("ar_pc", if_id_pc, 32'h0);
    imem_ack = 1'b0;
    model_reset();
    tb_pc = 32'h0100_0000;
    @(posedge clock);
    #2 reset = 1'b1;
    step(0, 1, 1, 32'h0);
    chk("ar_idle_req", 32'(imem_req), 32'd0);
    step(0, 1, 1, 32'h0);
    chk("ar_second_req", 32'(imem_req), 32'd1);
    chk("ar_second_addr", imem_addr, 32'h0100_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
